off_chip_link_gen2: RTL and testbench
=====================================

// Module: off_chip_link_gen2
// PURPOSE
//  Parametrised successor of the off-chip link model. It takes DATA_W-bit words over a valid/ready port and splits each into BEATS = DATA_W/LINK_W beats.
//  Beats are written into a DEPTH-entry narrow memory FIFO that models the link, then reassembled into the original word on a valid/ready output.
//  Flow control is credit-based and lossless. Storage format is selectable per word: contiguous or byte-striped.
//  The block sits between the host packer and the off-chip model in the verification environment.
// PARAMETERS
//  DATA_W  64  input/output word width; multiple of LINK_W
//  LINK_W  32  link beat width; LINK_W % BEATS == 0
//  DEPTH   8   FIFO entries in beats; power of 2, >= 2*BEATS
// PORTS
//  clk        in   1           clock, all flops on rising edge
//  rst        in   1           reset, asynchronous, active-low
//  in_data    in   DATA_W      input word
//  in_valid   in   1           input word valid
//  in_ready   out  1           block can accept a word this cycle
//  stripe_en  in   1           storage mode for the word accepted this cycle (1 = striped)
//  out_data   out  DATA_W      reassembled word
//  out_valid  out  1           out_data valid
//  out_ready  in   1           sink accepts out_data
//  link_data  out  LINK_W      beat being written to FIFO (observation tap)
//  link_valid out  1           link_data written at this edge
//  level      out  clog2(DEPTH+1)  reserved FIFO entries (credit counter)
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0 (in_ready forced 0), FIFO pointers, level and FSMs cleared. Partial words are discarded.
//  Accept: in_valid && in_ready. stripe_en is sampled with the word and stored with every beat (FIFO entry = LINK_W+1 bits).
//  Contiguous mode: beat k = in_data[k*LINK_W +: LINK_W].
//  Striped mode: lane l = in_data[l*LINK_W +: LINK_W]; chunk c of a lane is LINK_W/BEATS bits.
//    Beat k = {chunk k of lane BEATS-1, ..., chunk k of lane 0}.
//  Write FSM: IDLE -> SEND, with beat counter 0..BEATS-1.
//    One beat is written per cycle in SEND, with link_valid=1.
//    A new word may be accepted in the last SEND cycle, giving back-to-back words; otherwise the FSM returns to IDLE.
//  in_ready = (FSM==IDLE or last SEND beat) && (level <= DEPTH-BEATS).
//  level: +BEATS on accept, -1 per FIFO pop. On accept and pop in the same cycle, level changes by +BEATS-1. level never exceeds DEPTH.
//  Read side:
//    - Pops one beat per cycle into the assembly buffer while the FIFO is non-empty and the buffer is incomplete.
//    - Decodes beats using the stored mode bit.
//    - When the buffer completes, the word moves to the output register if !out_valid, or if out_valid && out_ready in that same cycle.
//    - With the output register full and no handshake, the completed buffer holds and popping stops.
//  out_data/out_valid are stable while out_valid && !out_ready. out_valid drops after a handshake unless the next word loads in that cycle.
//  Latency (empty FIFO, out_ready=1): word accepted in cycle 0, out_valid in cycle BEATS+2.
//  Sustained throughput: 1 word per BEATS cycles.
//  Pointers are clog2(DEPTH) bits and wrap naturally. Empty/full are derived from level and the pop count, never from pointer compare alone.
//  End-to-end transform is identity in both modes. Order is preserved, with no loss or duplication.
// TESTING
//  T1 contiguous: in 0x0706050403020100, stripe 0 -> link 0x03020100 then 0x07060504; out_data identical at cycle 4.
//  T2 striped: same word, stripe 1 -> link 0x05040100 then 0x07060302; out_data 0x0706050403020100.
//  T3 backpressure: out_ready=0, stream words 1..8 -> in_ready low after 6th accept, level=8.
//     Then out_ready=1 -> words 1..8 out in order, no duplicates.
//  T4 mixed: 200 random words, random stripe_en, random in_valid/out_ready -> output sequence equals input sequence;
//     level returns to 0 when traffic stops.
//  T5 reset mid-word: rst=0 during 2nd beat -> all outputs 0 immediately, level=0.
//     First post-reset word 0xA5A5... delivered exactly once, no stale beats.
//  T6 DATA_W=128, LINK_W=32, striped -> beat0 = {in[103:96],in[71:64],in[39:32],in[7:0]}; out_valid at cycle 6; output equals input.

Source files
------------

// File: rtl/off_chip_link_gen2.sv
// Off-chip link model, second generation: splits words into link beats, passes them through a
// credit-managed narrow FIFO and reassembles them, with per-word contiguous or byte-striped storage.
//
// write FSM states
//   state | meaning
//   IDLE  | no word held, waiting for an accept
//   SEND  | writing beat cnt_q of the held word into the FIFO
module off_chip_link_gen2 #(
  parameter int DATA_W = 64,
  parameter int LINK_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       stripe_en,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LINK_W-1:0]          link_data,
  output logic                       link_valid,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int BEATS = DATA_W / LINK_W;
  localparam int CHUNK = LINK_W / BEATS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ASM_W = $clog2(BEATS + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SEND} wr_state_t;

  wr_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q;
  logic              mode_q;
  logic              last_beat, accept;
  logic [LINK_W-1:0] beat_w;

  assign last_beat = (state_q == SEND) && (cnt_q == CNT_W'(BEATS - 1));
  // in_ready is gated by rst so it reads 0 while reset is asserted
  assign in_ready  = rst && ((state_q == IDLE) || last_beat) && (level <= LVL_W'(DEPTH - BEATS));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (last_beat) begin
          cnt_d   = '0;
          state_d = accept ? SEND : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        word_q <= in_data;
        mode_q <= stripe_en;
      end
    end
  end

  always_comb begin
    beat_w = word_q[int'(cnt_q)*LINK_W +: LINK_W];
    if (mode_q) begin
      for (int l = 0; l < BEATS; l++)
        beat_w[l*CHUNK +: CHUNK] = word_q[l*LINK_W + int'(cnt_q)*CHUNK +: CHUNK];
    end
  end

  assign link_valid = (state_q == SEND);
  assign link_data  = link_valid ? beat_w : '0;

  // FIFO entry = {mode bit, beat}
  logic [LINK_W:0]       mem [DEPTH];
  logic [PTR_W-1:0]      wptr, rptr;
  logic [LVL_W-1:0]      used;
  logic [LINK_W:0]       rd_ent;
  logic [LINK_W-1:0]     asm_q [BEATS];
  logic [LINK_W-1:0]     cur [BEATS];
  logic                  asm_mode_q, cur_mode;
  logic [ASM_W-1:0]      asm_cnt;
  logic                  buf_full, pop, complete_now, load_ok, load;
  logic [DATA_W-1:0]     word_d;

  always_ff @(posedge clk) begin
    if (link_valid) mem[wptr] <= {mode_q, beat_w};
  end

  assign rd_ent       = mem[rptr];
  assign buf_full     = (asm_cnt == ASM_W'(BEATS));
  assign pop          = (used != '0) && !buf_full;
  assign complete_now = pop && (asm_cnt == ASM_W'(BEATS - 1));
  assign load_ok      = !out_valid || out_ready;
  assign load         = (buf_full || complete_now) && load_ok;

  // the beat being popped joins the buffer combinationally so a completing word loads at once
  always_comb begin
    for (int k = 0; k < BEATS; k++)
      cur[k] = (pop && (asm_cnt == ASM_W'(k))) ? rd_ent[LINK_W-1:0] : asm_q[k];
    cur_mode = pop ? rd_ent[LINK_W] : asm_mode_q;
    word_d   = '0;
    for (int k = 0; k < BEATS; k++)
      word_d[k*LINK_W +: LINK_W] = cur[k];
    if (cur_mode) begin
      for (int k = 0; k < BEATS; k++)
        for (int l = 0; l < BEATS; l++)
          word_d[l*LINK_W + k*CHUNK +: CHUNK] = cur[k][l*CHUNK +: CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      used       <= '0;
      level      <= '0;
      asm_cnt    <= '0;
      asm_mode_q <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      for (int k = 0; k < BEATS; k++) asm_q[k] <= '0;
    end else begin
      if (link_valid) wptr <= wptr + 1'b1;
      if (pop)        rptr <= rptr + 1'b1;

      case ({link_valid, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase

      case ({accept, pop})
        2'b10:   level <= level + LVL_W'(BEATS);
        2'b01:   level <= level - 1'b1;
        2'b11:   level <= level + LVL_W'(BEATS - 1);
        default: level <= level;
      endcase

      if (pop) begin
        asm_mode_q <= rd_ent[LINK_W];
        for (int k = 0; k < BEATS; k++)
          if (asm_cnt == ASM_W'(k)) asm_q[k] <= rd_ent[LINK_W-1:0];
      end

      if (load)     asm_cnt <= '0;
      else if (pop) asm_cnt <= asm_cnt + 1'b1;

      if (load) begin
        out_data  <= word_d;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_off_chip_link_gen2.sv
// Scoreboard bench for off_chip_link_gen2: directed latency/format cases, backpressure,
// random traffic, mid-word reset, plus a 128-bit striped instance.
module tb_off_chip_link_gen2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] in_data, out_data;
  logic        in_valid, in_ready, stripe_en, out_valid, out_ready;
  logic [31:0] link_data;
  logic        link_valid;
  logic [3:0]  level;

  logic [127:0] in6, out6;
  logic         in_valid6, in_ready6, out_valid6;
  logic [31:0]  link6;
  logic         link_valid6;
  logic [3:0]   level6;

  off_chip_link_gen2 u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .stripe_en(stripe_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .link_data(link_data), .link_valid(link_valid), .level(level)
  );

  off_chip_link_gen2 #(.DATA_W(128), .LINK_W(32), .DEPTH(8)) u_dut6 (
    .clk(clk), .rst(rst), .in_data(in6), .in_valid(in_valid6), .in_ready(in_ready6),
    .stripe_en(1'b1), .out_data(out6), .out_valid(out_valid6), .out_ready(1'b1),
    .link_data(link6), .link_valid(link_valid6), .level(level6)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [63:0] sb[$];
  int          n_acc = 0;
  int          n_out = 0;
  logic        stall_q = 1'b0;
  logic [63:0] stall_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        n_acc++;
      end
      if (stall_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
        else chk("sb_data", out_data, sb.pop_front());
      end
      stall_q    <= out_valid && !out_ready;
      stall_data <= out_data;
    end else begin
      stall_q <= 1'b0;
    end
  end

  // out_ready driver: 0 = hold low, 1 = hold high, 2 = random
  int or_mode = 1;
  initial begin
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input logic [63:0] d, input logic s, input int max_wait, output bit ok);
    in_data = d; stripe_en = s; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic t_lat(input logic [63:0] d, input logic s, input logic [31:0] b0, input logic [31:0] b1);
    @(posedge clk); #1;
    in_data = d; stripe_en = s; in_valid = 1'b1;
    @(negedge clk); chk("lat_accept", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk("lat_lv0", link_valid, 1); chk("lat_beat0", link_data, b0);
    @(negedge clk); chk("lat_lv1", link_valid, 1); chk("lat_beat1", link_data, b1);
    @(negedge clk); chk("lat_ov_c3", out_valid, 0);
    @(negedge clk); chk("lat_ov_c4", out_valid, 1); chk("lat_data", out_data, d);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && !(sb.size() == 0 && !out_valid && level == 0); i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_level0"}, level, 0);
    chk({tag, "_count"}, n_out, n_acc);
    @(posedge clk); #1;
  endtask

  bit           ok;
  int           acc3;
  int           out_base;
  logic [127:0] w6;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; stripe_en = 1'b0; out_ready = 1'b1;
    in6 = '0; in_valid6 = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_link_valid", link_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready6", in_ready6, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    t_lat(64'h0706050403020100, 1'b0, 32'h03020100, 32'h07060504);
    t_lat(64'h0706050403020100, 1'b1, 32'h05040100, 32'h07060302);
    drain("t12");

    or_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    acc3 = 0;
    for (int w = 1; w <= 7; w++) begin
      send(64'(w), 1'(w & 1), 30, ok);
      if (ok) acc3++;
    end
    @(negedge clk);
    chk("bp_accepts", acc3, 6);
    chk("bp_level", level, 8);
    chk("bp_in_ready", in_ready, 0);
    @(posedge clk); #1;
    or_mode = 1;
    send(64'd7, 1'b1, 30, ok); chk("bp_send7", ok, 1);
    send(64'd8, 1'b0, 30, ok); chk("bp_send8", ok, 1);
    drain("t3");

    or_mode = 2;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 60, ok);
      chk("t4_send", ok, 1);
    end
    or_mode = 1;
    drain("t4");

    in_data = 64'h1122334455667788; stripe_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    n_acc = n_out;
    #1;
    chk("t5_in_ready", in_ready, 0);
    chk("t5_link_valid", link_valid, 0);
    chk("t5_link_data", link_data, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_level", level, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    out_base = n_out;
    send(64'hA5A5A5A5A5A5A5A5, 1'b1, 30, ok); chk("t5_send", ok, 1);
    repeat (20) begin @(posedge clk); #1; end
    chk("t5_once", n_out - out_base, 1);
    drain("t5");

    w6 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    in6 = w6; in_valid6 = 1'b1;
    @(negedge clk); chk("t6_accept", in_ready6, 1);
    @(posedge clk); #1; in_valid6 = 1'b0;
    @(negedge clk);
    chk("t6_lv0", link_valid6, 1);
    chk("t6_beat0", link6, {w6[103:96], w6[71:64], w6[39:32], w6[7:0]});
    @(negedge clk);
    chk("t6_beat1", link6, {w6[111:104], w6[79:72], w6[47:40], w6[15:8]});
    repeat (3) @(negedge clk);
    chk("t6_ov_c5", out_valid6, 0);
    @(negedge clk);
    chk("t6_ov_c6", out_valid6, 1);
    chk("t6_data", out6, w6);
    @(negedge clk);
    chk("t6_ov_drop", out_valid6, 0);
    chk("t6_level0", level6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
